// File: rtl/fsm_seq4_detect.sv
// Run-length detector: tracks consecutive identical bits sampled on rising
// edges of a (optionally synchronized) step request; flags runs of four or more.
module fsm_seq4_detect #(
  parameter int unsigned CNT_W = 8,
  parameter bit          SYNC  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_bit,
  input  logic             step,
  output logic [3:0]       state_key,
  output logic             z,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  logic [3:0] state;
  state_t     nxt;
  logic       in_s;
  logic       step_s;
  logic       step_d;
  logic       adv;
  logic       legal;
  logic       nxt_hit;

  if (SYNC) begin : g_sync
    logic [1:0] in_ff;
    logic [1:0] step_ff;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_ff   <= '0;
        step_ff <= '0;
      end else begin
        in_ff   <= {in_ff[0], in_bit};
        step_ff <= {step_ff[0], step};
      end
    end
    assign in_s   = in_ff[1];
    assign step_s = step_ff[1];
  end else begin : g_bypass
    assign in_s   = in_bit;
    assign step_s = step;
  end

  // Edge detector is deliberately untouched by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_d <= 1'b0;
    else     step_d <= step_s;
  end

  assign adv   = step_s & ~step_d;
  assign legal = (state <= 4'd8);

  always_comb begin
    nxt = S0;
    case (state)
      S0:      nxt = in_s ? S5 : S1;
      S1:      nxt = in_s ? S5 : S2;
      S2:      nxt = in_s ? S5 : S3;
      S3:      nxt = in_s ? S5 : S4;
      S4:      nxt = in_s ? S5 : S4;
      S5:      nxt = in_s ? S6 : S1;
      S6:      nxt = in_s ? S7 : S1;
      S7:      nxt = in_s ? S8 : S1;
      S8:      nxt = in_s ? S8 : S1;
      default: nxt = S0;
    endcase
  end

  assign nxt_hit = (nxt == S4) || (nxt == S8);

  // z is registered alongside the state so it always equals (state is S4/S8).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S0;
      z       <= 1'b0;
      hit_cnt <= '0;
    end else if (clr) begin
      state   <= S0;
      z       <= 1'b0;
      hit_cnt <= '0;
    end else if (!legal) begin
      state <= S0;
      z     <= 1'b0;
    end else if (adv) begin
      state <= nxt;
      z     <= nxt_hit;
      if (nxt_hit) hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

  assign state_key = state;

endmodule

// File: tb/tb_fsm_seq4_detect.sv
// Directed bench: default instance (SYNC=1, CNT_W=8) plus a SYNC=0, CNT_W=2
// instance sharing all inputs, used for bypass latency and counter wrap.
module tb_fsm_seq4_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_bit = 1'b0;
  logic       step = 1'b0;
  logic [3:0] key_a;
  logic       z_a;
  logic [7:0] hit_a;
  logic [3:0] key_b;
  logic       z_b;
  logic [1:0] hit_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fsm_seq4_detect #(.CNT_W(8), .SYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_bit(in_bit), .step(step),
    .state_key(key_a), .z(z_a), .hit_cnt(hit_a)
  );

  fsm_seq4_detect #(.CNT_W(2), .SYNC(1'b0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_bit(in_bit), .step(step),
    .state_key(key_b), .z(z_b), .hit_cnt(hit_b)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; clr = 1'b0; in_bit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One clean step pulse; returns at a negedge after both instances updated.
  task automatic pulse(input logic b);
    @(negedge clk);
    in_bit = b;
    step   = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (key_a !== 4'd0 || z_a !== 1'b0 || hit_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_a: key=%0d z=%b hit=%0d expected 0/0/0", key_a, z_a, hit_a);
    end
    checks++;
    if (key_b !== 4'd0 || z_b !== 1'b0 || hit_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_b: key=%0d z=%b hit=%0d expected 0/0/0", key_b, z_b, hit_b);
    end
    do_reset();
  endtask

  task automatic test_four_zeros();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_bit = 1'b0;
      step   = 1'b1;
      @(negedge clk);
      checks++;
      if (key_a !== 4'(i) || key_b !== 4'(i + 1)) begin
        errors++;
        $display("FAIL lat_edge_k[%0d]: a=%0d b=%0d expected a=%0d b=%0d", i, key_a, key_b, i, i + 1);
      end
      @(negedge clk);
      checks++;
      if (key_a !== 4'(i)) begin
        errors++;
        $display("FAIL lat_edge_k1[%0d]: key=%0d expected %0d", i, key_a, i);
      end
      @(negedge clk);
      checks++;
      if (key_a !== 4'(i + 1) || z_a !== (i == 3)) begin
        errors++;
        $display("FAIL lat_edge_k2[%0d]: key=%0d z=%b expected %0d z=%b", i, key_a, z_a, i + 1, (i == 3));
      end
      step = 1'b0;
      repeat (3) @(negedge clk);
    end
    checks++;
    if (hit_a !== 8'd1) begin
      errors++;
      $display("FAIL four_zeros_hit: hit=%0d expected 1", hit_a);
    end
  endtask

  task automatic test_run_switch();
    logic [5:0] bits = 6'b111100;
    logic [3:0] exp_key [6] = '{4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [7:0] exp_hit [6] = '{8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    logic       exp_z   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      pulse(bits[i]);
      checks++;
      if (key_a !== exp_key[i] || hit_a !== exp_hit[i] || z_a !== exp_z[i]) begin
        errors++;
        $display("FAIL run_switch[%0d]: key=%0d hit=%0d z=%b expected %0d %0d %b",
                 i, key_a, hit_a, z_a, exp_key[i], exp_hit[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_held_step();
    @(negedge clk);
    in_bit = 1'b0;
    step   = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (key_a !== 4'd1 || hit_a !== 8'd4 || key_b !== 4'd1) begin
      errors++;
      $display("FAIL held_step: a=%0d hit=%0d b=%0d expected 1 4 1", key_a, hit_a, key_b);
    end
    step = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (key_a !== 4'd1) begin
      errors++;
      $display("FAIL falling_edge: key=%0d expected 1", key_a);
    end
    for (int i = 0; i < 8; i++) begin
      pulse((i % 2) == 0);
      checks++;
      if (key_a !== (((i % 2) == 0) ? 4'd5 : 4'd1) || z_a !== 1'b0) begin
        errors++;
        $display("FAIL alternate[%0d]: key=%0d z=%b expected %0d z=0",
                 i, key_a, z_a, ((i % 2) == 0) ? 5 : 1);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_b [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0);
      checks++;
      if (hit_b !== exp_b[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: hit_b=%0d expected %0d", i, hit_b, exp_b[i]);
      end
    end
    checks++;
    if (hit_a !== 8'd4) begin
      errors++;
      $display("FAIL wrap_wide: hit_a=%0d expected 4", hit_a);
    end
  endtask

  task automatic test_clr_priority();
    logic [7:0] seq = 8'b00010000;
    do_reset();
    for (int i = 0; i < 8; i++) pulse(seq[i]);
    checks++;
    if (key_a !== 4'd3 || hit_a !== 8'd1) begin
      errors++;
      $display("FAIL clr_setup: key=%0d hit=%0d expected 3 1", key_a, hit_a);
    end
    @(negedge clk);
    in_bit = 1'b0;
    step   = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (key_a !== 4'd0 || hit_a !== 8'd0 || z_a !== 1'b0) begin
      errors++;
      $display("FAIL clr_adv: key=%0d hit=%0d z=%b expected 0 0 0", key_a, hit_a, z_a);
    end
    step = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (key_a !== 4'd0 || hit_a !== 8'd0 || key_b !== 4'd0 || hit_b !== 2'd0) begin
      errors++;
      $display("FAIL clr_no_defer: a=%0d/%0d b=%0d/%0d expected all 0", key_a, hit_a, key_b, hit_b);
    end
  endtask

  task automatic test_rst_async();
    for (int i = 0; i < 4; i++) pulse(1'b0);
    checks++;
    if (key_a !== 4'd4 || z_a !== 1'b1 || hit_a !== 8'd1) begin
      errors++;
      $display("FAIL rst_setup: key=%0d z=%b hit=%0d expected 4 1 1", key_a, z_a, hit_a);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (key_a !== 4'd0 || z_a !== 1'b0 || hit_a !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: key=%0d z=%b hit=%0d expected 0 0 0", key_a, z_a, hit_a);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_step();
    @(negedge clk);
    rst    = 1'b1;
    in_bit = 1'b1;
    step   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (key_a !== 4'd5 || key_b !== 4'd5) begin
      errors++;
      $display("FAIL rst_step: a=%0d b=%0d expected 5 5", key_a, key_b);
    end
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_illegal();
    do_reset();
    for (int i = 0; i < 4; i++) pulse(1'b0);
    pulse(1'b1);
    @(negedge clk);
    force dut.state = 4'd11;
    release dut.state;
    @(negedge clk);
    checks++;
    if (key_a !== 4'd0 || hit_a !== 8'd1 || z_a !== 1'b0) begin
      errors++;
      $display("FAIL illegal: key=%0d hit=%0d z=%b expected 0 1 0", key_a, hit_a, z_a);
    end
  endtask

  initial begin
    test_reset();
    test_four_zeros();
    test_run_switch();
    test_held_step();
    test_wrap();
    test_clr_priority();
    test_rst_async();
    test_rst_step();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
